decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_if.sv | 57 +++++
 rtl/decode.sv | 258 +++++++++++++++++++++++++
 tb/tb_decode.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Decode-stage bus: IF/ID inputs, downstream stall/forward status, the
// register-file write port, and the registered ID/EX pipeline outputs.
// The slave modport is the decode stage; master is whatever surrounds it.
interface decode_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    // fetch -> decode
    logic [ADDRESS_SIZE-1:0] IF_ID_nextPC;
    logic [DATA_SIZE-1:0]    IF_ID_IR;
    // downstream stall requests and MEM-stage destination
    logic                    ex_stall_c;
    logic                    mem_stall_c;
    logic                    EX_MEM_reg_write;
    logic [4:0]              EX_MEM_rd;
    // write-back port into the register file
    logic                    wb_write_enable;
    logic [4:0]              wb_write_reg;
    logic [DATA_SIZE-1:0]    wb_write_data;
    // combinational feedback to fetch
    logic                    id_stall_c;
    logic                    branch_c;
    logic [ADDRESS_SIZE-1:0] branch_pc;
    // ID/EX pipeline register
    logic [ADDRESS_SIZE-1:0] ID_EX_nextPC;
    logic [DATA_SIZE-1:0]    ID_EX_A;
    logic [DATA_SIZE-1:0]    ID_EX_B;
    logic [DATA_SIZE-1:0]    ID_EX_imm;
    logic [4:0]              ID_EX_rs;
    logic [4:0]              ID_EX_rt;
    logic [4:0]              ID_EX_rd;
    logic [2:0]              ID_EX_alu_op;
    logic                    ID_EX_alu_src_imm;
    logic                    ID_EX_mem_read;
    logic                    ID_EX_mem_write;
    logic                    ID_EX_reg_write;

    modport slave (
        input  IF_ID_nextPC, IF_ID_IR, ex_stall_c, mem_stall_c,
               EX_MEM_reg_write, EX_MEM_rd,
               wb_write_enable, wb_write_reg, wb_write_data,
        output id_stall_c, branch_c, branch_pc,
               ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_alu_op,
               ID_EX_alu_src_imm, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write
    );

    modport master (
        output IF_ID_nextPC, IF_ID_IR, ex_stall_c, mem_stall_c,
               EX_MEM_reg_write, EX_MEM_rd,
               wb_write_enable, wb_write_reg, wb_write_data,
        input  id_stall_c, branch_c, branch_pc,
               ID_EX_nextPC, ID_EX_A, ID_EX_B, ID_EX_imm,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_alu_op,
               ID_EX_alu_src_imm, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write
    );
endinterface

// File: rtl/decode.sv
// MIPS-subset instruction decode stage: register file with write-through
// bypass, instruction decode, load-use / branch hazard detection, branch
// resolution in ID (one delay slot, no flush) and the ID/EX register.
module decode #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic     clock,
    input  logic     reset_n,
    decode_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] next_pc;
        logic [DATA_SIZE-1:0]    a;
        logic [DATA_SIZE-1:0]    b;
        logic [DATA_SIZE-1:0]    imm;
        logic [4:0]              rs;
        logic [4:0]              rt;
        logic [4:0]              rd;
        logic [2:0]              alu_op;
        logic                    alu_src_imm;
        logic                    mem_read;
        logic                    mem_write;
        logic                    reg_write;
    } idex_t;

    // instruction fields
    logic [DATA_SIZE-1:0] ir;
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd_field;
    logic [DATA_SIZE-1:0] imm_ext;

    assign ir       = bus.IF_ID_IR;
    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd_field = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_ext  = {{(DATA_SIZE-16){ir[15]}}, ir[15:0]};

    // register file and its read ports
    logic [DATA_SIZE-1:0] regs_q [32];
    logic [DATA_SIZE-1:0] rd_a;
    logic [DATA_SIZE-1:0] rd_b;

    // decode results
    logic       valid;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] dest;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;

    // hazards / branch
    logic       load_use;
    logic       branch_haz;
    logic       id_stall;
    logic       down_stall;
    logic       taken;
    logic [ADDRESS_SIZE-1:0] br_off;

    idex_t idex_q;
    idex_t idex_d;
    idex_t dec_w;

    // Register file: r0 is never written; reset clears everything and wins over writes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (bus.wb_write_enable && bus.wb_write_reg != 5'd0) begin
            regs_q[bus.wb_write_reg] <= bus.wb_write_data;
        end
    end

    // Read ports with write-through so a same-cycle WB is seen by decode.
    always_comb begin
        rd_a = regs_q[rs];
        rd_b = regs_q[rt];
        if (rs == 5'd0)
            rd_a = '0;
        else if (bus.wb_write_enable && bus.wb_write_reg == rs)
            rd_a = bus.wb_write_data;
        if (rt == 5'd0)
            rd_b = '0;
        else if (bus.wb_write_enable && bus.wb_write_reg == rt)
            rd_b = bus.wb_write_data;
    end

    // Opcode/funct decode; anything unrecognised stays invalid and becomes a bubble.
    always_comb begin
        valid       = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        dest        = 5'd0;
        reads_rs    = 1'b0;
        reads_rt    = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_j        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                valid    = 1'b1;
                dest     = rd_field;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: begin
                        valid    = 1'b0;
                        dest     = 5'd0;
                        reads_rs = 1'b0;
                        reads_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                valid       = 1'b1;
                alu_src_imm = 1'b1;
                dest        = rt;
                reads_rs    = 1'b1;
            end
            OP_LW: begin
                valid       = 1'b1;
                alu_src_imm = 1'b1;
                mem_read    = 1'b1;
                dest        = rt;
                reads_rs    = 1'b1;
            end
            OP_SW: begin
                valid       = 1'b1;
                alu_src_imm = 1'b1;
                mem_write   = 1'b1;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            OP_BEQ: begin
                valid    = 1'b1;
                is_beq   = 1'b1;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_BNE: begin
                valid    = 1'b1;
                is_bne   = 1'b1;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_J: begin
                valid = 1'b1;
                is_j  = 1'b1;
            end
            default: ;
        endcase
    end

    // Pack the decoded instruction; invalid encodings produce an all-zero bubble.
    always_comb begin
        dec_w = '0;
        if (valid) begin
            dec_w.next_pc     = bus.IF_ID_nextPC;
            dec_w.a           = rd_a;
            dec_w.b           = rd_b;
            dec_w.imm         = imm_ext;
            dec_w.rs          = rs;
            dec_w.rt          = rt;
            dec_w.rd          = dest;
            dec_w.alu_op      = alu_op;
            dec_w.alu_src_imm = alu_src_imm;
            dec_w.mem_read    = mem_read;
            dec_w.mem_write   = mem_write;
            dec_w.reg_write   = (dest != 5'd0);
        end
    end

    // Hazards: load-use on any real source operand; branches compare in ID so
    // they must also wait for any in-flight producer in EX or MEM.
    always_comb begin
        load_use   = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                     ((reads_rs && idex_q.rd == rs) || (reads_rt && idex_q.rd == rt));
        branch_haz = (is_beq || is_bne) &&
                     ((idex_q.reg_write && (idex_q.rd == rs || idex_q.rd == rt)) ||
                      (bus.EX_MEM_reg_write && bus.EX_MEM_rd != 5'd0 &&
                       (bus.EX_MEM_rd == rs || bus.EX_MEM_rd == rt)));
        id_stall   = reset_n && (load_use || branch_haz);
        down_stall = bus.ex_stall_c || bus.mem_stall_c;
        taken      = (is_beq && rd_a == rd_b) || (is_bne && rd_a != rd_b) || is_j;
    end

    assign br_off         = {{(ADDRESS_SIZE-18){ir[15]}}, ir[15:0], 2'b00};
    assign bus.id_stall_c = id_stall;
    assign bus.branch_c   = reset_n && !id_stall && !down_stall && taken;
    assign bus.branch_pc  = is_j ? {bus.IF_ID_nextPC[ADDRESS_SIZE-1:28], ir[25:0], 2'b00}
                                 : bus.IF_ID_nextPC + br_off;

    // ID/EX next state: downstream stall holds, hazard inserts a bubble.
    always_comb begin
        idex_d = dec_w;
        if (down_stall)
            idex_d = idex_q;
        else if (id_stall)
            idex_d = '0;
    end

    // ID/EX register.
    always_ff @(posedge clock) begin
        if (!reset_n)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign bus.ID_EX_nextPC      = idex_q.next_pc;
    assign bus.ID_EX_A           = idex_q.a;
    assign bus.ID_EX_B           = idex_q.b;
    assign bus.ID_EX_imm         = idex_q.imm;
    assign bus.ID_EX_rs          = idex_q.rs;
    assign bus.ID_EX_rt          = idex_q.rt;
    assign bus.ID_EX_rd          = idex_q.rd;
    assign bus.ID_EX_alu_op      = idex_q.alu_op;
    assign bus.ID_EX_alu_src_imm = idex_q.alu_src_imm;
    assign bus.ID_EX_mem_read    = idex_q.mem_read;
    assign bus.ID_EX_mem_write   = idex_q.mem_write;
    assign bus.ID_EX_reg_write   = idex_q.reg_write;
endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed scenarios with literal expectations,
// plus randomized traffic against a rule-level reference model.
module tb_decode;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    decode_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();
    decode #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] npc; logic [31:0] a; logic [31:0] b; logic [31:0] imm;
        logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic [2:0] op;
        logic src; logic mr; logic mw; logic rw;
    } ex_t;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_ADDI = 5,
                   K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_J = 10, K_BAD = 11;

    logic [31:0] m_regs [32];
    ex_t         m_idex;

    function automatic ex_t dut_idex();
        return ex_t'({bus.ID_EX_nextPC, bus.ID_EX_A, bus.ID_EX_B, bus.ID_EX_imm,
                      bus.ID_EX_rs, bus.ID_EX_rt, bus.ID_EX_rd, bus.ID_EX_alu_op,
                      bus.ID_EX_alu_src_imm, bus.ID_EX_mem_read, bus.ID_EX_mem_write,
                      bus.ID_EX_reg_write});
    endfunction

    function automatic logic [31:0] rtype(int s, int t, int d, logic [5:0] fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
    endfunction
    function automatic logic [31:0] itype(logic [5:0] op, int s, int t, logic [15:0] imm);
        return {op, 5'(s), 5'(t), imm};
    endfunction

    // Instruction class from the ISA table.
    function automatic int kind_of(logic [31:0] ir);
        logic [5:0] fn;
        fn = ir[5:0];
        case (ir[31:26])
            6'h00: begin
                if (fn == 6'h20) return K_ADD;
                if (fn == 6'h22) return K_SUB;
                if (fn == 6'h24) return K_AND;
                if (fn == 6'h25) return K_OR;
                if (fn == 6'h2A) return K_SLT;
                return K_BAD;
            end
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.wb_write_enable && bus.wb_write_reg == r) return bus.wb_write_data;
        return m_regs[r];
    endfunction

    function automatic ex_t m_decode(logic [31:0] ir, logic [31:0] npc);
        ex_t e;
        int  k;
        e = '0;
        k = kind_of(ir);
        if (k == K_BAD) return e;
        e.npc = npc;
        e.a   = m_read(ir[25:21]);
        e.b   = m_read(ir[20:16]);
        e.imm = 32'($signed(ir[15:0]));
        e.rs  = ir[25:21];
        e.rt  = ir[20:16];
        if (k <= K_SLT) e.rd = ir[15:11];
        else if (k == K_ADDI || k == K_LW) e.rd = ir[20:16];
        e.op  = (k <= K_SLT) ? 3'(k) : 3'd0;
        e.src = (k == K_ADDI || k == K_LW || k == K_SW);
        e.mr  = (k == K_LW);
        e.mw  = (k == K_SW);
        e.rw  = (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic m_stall(logic [31:0] ir);
        int k;
        logic [4:0] s, t;
        logic use_s, use_t, lu, bh;
        k = kind_of(ir);
        s = ir[25:21];
        t = ir[20:16];
        use_s = (k != K_BAD && k != K_J);
        use_t = (k <= K_SLT || k == K_SW || k == K_BEQ || k == K_BNE);
        lu = m_idex.mr && m_idex.rd != 0 && ((use_s && m_idex.rd == s) || (use_t && m_idex.rd == t));
        bh = (k == K_BEQ || k == K_BNE) &&
             ((m_idex.rw && (m_idex.rd == s || m_idex.rd == t)) ||
              (bus.EX_MEM_reg_write && bus.EX_MEM_rd != 0 && (bus.EX_MEM_rd == s || bus.EX_MEM_rd == t)));
        return reset_n && (lu || bh);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        bus.IF_ID_nextPC = 32'd0; bus.IF_ID_IR = 32'd0;
        bus.ex_stall_c = 1'b0; bus.mem_stall_c = 1'b0;
        bus.EX_MEM_reg_write = 1'b0; bus.EX_MEM_rd = 5'd0;
        bus.wb_write_enable = 1'b0; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'd0;
    endtask

    task automatic wr_reg(int r, logic [31:0] v);
        bus.IF_ID_IR = 32'd0;
        bus.wb_write_enable = 1'b1; bus.wb_write_reg = 5'(r); bus.wb_write_data = v;
        tick();
        bus.wb_write_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_idle();
        bus.IF_ID_IR = itype(6'h04, 1, 2, 16'd3);
        bus.EX_MEM_reg_write = 1'b1; bus.EX_MEM_rd = 5'd1;
        bus.wb_write_enable = 1'b1; bus.wb_write_reg = 5'd4; bus.wb_write_data = 32'hDEAD;
        #1;
        checks++; if (bus.id_stall_c !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.id_stall_c); end
        bus.IF_ID_IR = {6'h02, 26'h40};
        #1;
        checks++; if (bus.branch_c !== 1'b0) begin errors++; $display("FAIL reset_branch got=%b exp=0", bus.branch_c); end
        tick(); tick();
        checks++; if (dut_idex() !== ex_t'(0)) begin errors++; $display("FAIL reset_idex got=%h exp=0", dut_idex()); end
        reset_n = 1'b1;
        set_idle();
        #1;
        checks++; if (bus.id_stall_c !== 1'b0 || bus.branch_c !== 1'b0) begin
            errors++; $display("FAIL post_reset_ctl stall=%b branch=%b exp=0/0", bus.id_stall_c, bus.branch_c); end
    endtask

    task automatic test_add_bypass();
        bus.IF_ID_IR = rtype(5, 0, 3, 6'h20); bus.IF_ID_nextPC = 32'h40;
        bus.wb_write_enable = 1'b1; bus.wb_write_reg = 5'd5; bus.wb_write_data = 32'h11;
        tick();
        bus.wb_write_enable = 1'b0;
        checks++; if (bus.ID_EX_A !== 32'h11 || bus.ID_EX_B !== 32'd0 || bus.ID_EX_rd !== 5'd3 ||
                      bus.ID_EX_reg_write !== 1'b1 || bus.ID_EX_alu_op !== 3'd0 || bus.ID_EX_nextPC !== 32'h40) begin
            errors++; $display("FAIL add_bypass A=%h B=%h rd=%0d rw=%b op=%0d exp A=11 B=0 rd=3 rw=1 op=0",
                               bus.ID_EX_A, bus.ID_EX_B, bus.ID_EX_rd, bus.ID_EX_reg_write, bus.ID_EX_alu_op); end
        bus.IF_ID_IR = rtype(5, 5, 6, 6'h2A);
        tick();
        checks++; if (bus.ID_EX_A !== 32'h11 || bus.ID_EX_B !== 32'h11 || bus.ID_EX_alu_op !== 3'd4) begin
            errors++; $display("FAIL add_stored A=%h B=%h op=%0d exp 11/11/4", bus.ID_EX_A, bus.ID_EX_B, bus.ID_EX_alu_op); end
    endtask

    task automatic test_load_use();
        wr_reg(1, 32'h100); wr_reg(3, 32'd3);
        bus.IF_ID_IR = itype(6'h23, 1, 2, 16'd4);
        tick();
        checks++; if (bus.ID_EX_mem_read !== 1'b1 || bus.ID_EX_rd !== 5'd2 || bus.ID_EX_A !== 32'h100 ||
                      bus.ID_EX_imm !== 32'd4 || bus.ID_EX_alu_src_imm !== 1'b1) begin
            errors++; $display("FAIL lw_decode mr=%b rd=%0d A=%h imm=%h", bus.ID_EX_mem_read, bus.ID_EX_rd, bus.ID_EX_A, bus.ID_EX_imm); end
        bus.IF_ID_IR = rtype(2, 3, 4, 6'h20);
        #1;
        checks++; if (bus.id_stall_c !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%b exp=1", bus.id_stall_c); end
        tick();
        checks++; if (dut_idex() !== ex_t'(0)) begin errors++; $display("FAIL load_use_bubble got=%h exp=0", dut_idex()); end
        #1;
        checks++; if (bus.id_stall_c !== 1'b0) begin errors++; $display("FAIL load_use_release got=%b exp=0", bus.id_stall_c); end
        tick();
        checks++; if (bus.ID_EX_rd !== 5'd4 || bus.ID_EX_reg_write !== 1'b1 || bus.ID_EX_B !== 32'd3 || bus.ID_EX_rs !== 5'd2) begin
            errors++; $display("FAIL load_use_issue rd=%0d rw=%b B=%h exp rd=4 rw=1 B=3", bus.ID_EX_rd, bus.ID_EX_reg_write, bus.ID_EX_B); end
    endtask

    task automatic test_branch();
        wr_reg(1, 32'd7); wr_reg(2, 32'd7);
        bus.IF_ID_IR = itype(6'h04, 1, 2, 16'd3); bus.IF_ID_nextPC = 32'h104;
        #1;
        checks++; if (bus.branch_c !== 1'b1 || bus.branch_pc !== 32'h110) begin
            errors++; $display("FAIL beq_taken br=%b pc=%h exp 1/110", bus.branch_c, bus.branch_pc); end
        bus.IF_ID_IR = itype(6'h05, 1, 2, 16'd3);
        #1;
        checks++; if (bus.branch_c !== 1'b0) begin errors++; $display("FAIL bne_not_taken got=%b exp=0", bus.branch_c); end
        bus.IF_ID_IR = itype(6'h04, 1, 2, 16'd3); bus.EX_MEM_reg_write = 1'b1; bus.EX_MEM_rd = 5'd2;
        #1;
        checks++; if (bus.id_stall_c !== 1'b1 || bus.branch_c !== 1'b0) begin
            errors++; $display("FAIL beq_exmem_haz stall=%b br=%b exp 1/0", bus.id_stall_c, bus.branch_c); end
        bus.EX_MEM_reg_write = 1'b0;
        bus.IF_ID_IR = itype(6'h08, 0, 1, 16'd7);
        tick();
        bus.IF_ID_IR = itype(6'h04, 1, 2, 16'd3);
        #1;
        checks++; if (bus.id_stall_c !== 1'b1) begin errors++; $display("FAIL beq_idex_haz got=%b exp=1", bus.id_stall_c); end
        tick();
        bus.IF_ID_IR = itype(6'h05, 1, 3, 16'hFFFE); bus.IF_ID_nextPC = 32'h200;
        #1;
        checks++; if (bus.branch_c !== 1'b1 || bus.branch_pc !== 32'h1F8) begin
            errors++; $display("FAIL bne_back br=%b pc=%h exp 1/1f8", bus.branch_c, bus.branch_pc); end
        tick();
        bus.IF_ID_IR = rtype(1, 2, 6, 6'h24); bus.IF_ID_nextPC = 32'h204;
        tick();
        checks++; if (bus.ID_EX_rd !== 5'd6 || bus.ID_EX_reg_write !== 1'b1 || bus.ID_EX_alu_op !== 3'd2 || bus.ID_EX_A !== 32'd7) begin
            errors++; $display("FAIL delay_slot rd=%0d rw=%b op=%0d exp 6/1/2", bus.ID_EX_rd, bus.ID_EX_reg_write, bus.ID_EX_alu_op); end
        bus.IF_ID_IR = {6'h02, 26'h40}; bus.IF_ID_nextPC = 32'h1000_0008;
        #1;
        checks++; if (bus.branch_c !== 1'b1 || bus.branch_pc !== 32'h1000_0100) begin
            errors++; $display("FAIL jump br=%b pc=%h exp 1/10000100", bus.branch_c, bus.branch_pc); end
        bus.ex_stall_c = 1'b1;
        #1;
        checks++; if (bus.branch_c !== 1'b0) begin errors++; $display("FAIL jump_ex_stall got=%b exp=0", bus.branch_c); end
        bus.ex_stall_c = 1'b0;
        tick();
        checks++; if (bus.ID_EX_reg_write !== 1'b0 || bus.ID_EX_mem_read !== 1'b0 || bus.ID_EX_mem_write !== 1'b0) begin
            errors++; $display("FAIL jump_ctl rw=%b mr=%b mw=%b exp 0/0/0", bus.ID_EX_reg_write, bus.ID_EX_mem_read, bus.ID_EX_mem_write); end
    endtask

    task automatic test_mem_stall();
        wr_reg(3, 32'd3);
        bus.IF_ID_IR = rtype(1, 3, 6, 6'h22); bus.IF_ID_nextPC = 32'h300;
        tick();
        bus.IF_ID_IR = itype(6'h08, 1, 7, 16'hFFFB); bus.IF_ID_nextPC = 32'h304;
        bus.mem_stall_c = 1'b1;
        bus.wb_write_enable = 1'b1; bus.wb_write_reg = 5'd9; bus.wb_write_data = 32'h99;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.branch_c !== 1'b0) begin errors++; $display("FAIL mem_stall_branch c=%0d got=%b", c, bus.branch_c); end
            tick();
            bus.wb_write_enable = 1'b0;
            checks++; if (bus.ID_EX_alu_op !== 3'd1 || bus.ID_EX_rd !== 5'd6 || bus.ID_EX_A !== 32'd7 ||
                          bus.ID_EX_B !== 32'd3 || bus.ID_EX_nextPC !== 32'h300 || bus.ID_EX_imm !== 32'h3022) begin
                errors++; $display("FAIL mem_stall_hold c=%0d op=%0d rd=%0d A=%h npc=%h exp 1/6/7/300", c,
                                   bus.ID_EX_alu_op, bus.ID_EX_rd, bus.ID_EX_A, bus.ID_EX_nextPC); end
        end
        bus.mem_stall_c = 1'b0;
        tick();
        checks++; if (bus.ID_EX_alu_op !== 3'd0 || bus.ID_EX_alu_src_imm !== 1'b1 || bus.ID_EX_rd !== 5'd7 ||
                      bus.ID_EX_imm !== 32'hFFFF_FFFB || bus.ID_EX_A !== 32'd7 || bus.ID_EX_nextPC !== 32'h304) begin
            errors++; $display("FAIL mem_stall_release op=%0d src=%b rd=%0d imm=%h", bus.ID_EX_alu_op,
                               bus.ID_EX_alu_src_imm, bus.ID_EX_rd, bus.ID_EX_imm); end
        bus.IF_ID_IR = rtype(9, 0, 8, 6'h25);
        tick();
        checks++; if (bus.ID_EX_A !== 32'h99) begin errors++; $display("FAIL stall_wb_write got=%h exp=99", bus.ID_EX_A); end
    endtask

    task automatic test_reset_mid();
        bus.IF_ID_IR = rtype(1, 2, 3, 6'h20);
        tick();
        checks++; if (bus.ID_EX_reg_write !== 1'b1) begin errors++; $display("FAIL mid_pre_rw got=%b exp=1", bus.ID_EX_reg_write); end
        reset_n = 1'b0;
        bus.mem_stall_c = 1'b1;
        bus.wb_write_enable = 1'b1; bus.wb_write_reg = 5'd5; bus.wb_write_data = 32'h55;
        tick();
        checks++; if (dut_idex() !== ex_t'(0)) begin errors++; $display("FAIL mid_reset_idex got=%h exp=0", dut_idex()); end
        reset_n = 1'b1;
        set_idle();
        for (int r = 1; r < 32; r++) begin
            bus.IF_ID_IR = rtype(r, r, 1, 6'h25);
            tick();
            checks++; if (bus.ID_EX_A !== 32'd0) begin errors++; $display("FAIL mid_reg_clear r%0d got=%h exp=0", r, bus.ID_EX_A); end
        end
    endtask

    function automatic logic [31:0] rand_ir();
        int s, t, d;
        s = $urandom_range(0, 7); t = $urandom_range(0, 7); d = $urandom_range(0, 7);
        case ($urandom_range(0, 12))
            0: return rtype(s, t, d, 6'h20);
            1: return rtype(s, t, d, 6'h22);
            2: return rtype(s, t, d, 6'h24);
            3: return rtype(s, t, d, 6'h25);
            4: return rtype(s, t, d, 6'h2A);
            5: return itype(6'h08, s, t, 16'($urandom));
            6: return itype(6'h23, s, t, 16'($urandom));
            7: return itype(6'h2B, s, t, 16'($urandom));
            8: return itype(6'h04, s, t, 16'($urandom));
            9: return itype(6'h05, s, t, 16'($urandom));
            10: return {6'h02, 26'($urandom)};
            11: return rtype(s, t, d, 6'($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ir, npc, exp_pc;
        logic        exp_stall, exp_br;
        ex_t         nxt;
        int          k;
        reset_n = 1'b0; set_idle(); tick(); reset_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_idex = '0;
        for (int n = 0; n < 600; n++) begin
            ir  = rand_ir();
            npc = $urandom;
            reset_n = ($urandom_range(0, 79) != 0);
            bus.IF_ID_IR = ir; bus.IF_ID_nextPC = npc;
            bus.ex_stall_c = ($urandom_range(0, 9) == 0);
            bus.mem_stall_c = ($urandom_range(0, 9) == 0);
            bus.EX_MEM_reg_write = $urandom_range(0, 1); bus.EX_MEM_rd = 5'($urandom_range(0, 7));
            bus.wb_write_enable = $urandom_range(0, 1); bus.wb_write_reg = 5'($urandom_range(0, 7));
            bus.wb_write_data = $urandom;
            #1;
            k = kind_of(ir);
            exp_stall = m_stall(ir);
            exp_br = reset_n && !exp_stall && !bus.ex_stall_c && !bus.mem_stall_c &&
                     ((k == K_BEQ && m_read(ir[25:21]) == m_read(ir[20:16])) ||
                      (k == K_BNE && m_read(ir[25:21]) != m_read(ir[20:16])) || k == K_J);
            if (k == K_J) exp_pc = {npc[31:28], ir[25:0], 2'b00};
            else          exp_pc = npc + (32'($signed(ir[15:0])) * 32'd4);
            checks++; if (bus.id_stall_c !== exp_stall) begin
                errors++; $display("FAIL rnd_stall n=%0d ir=%h got=%b exp=%b", n, ir, bus.id_stall_c, exp_stall); end
            checks++; if (bus.branch_c !== exp_br) begin
                errors++; $display("FAIL rnd_branch n=%0d ir=%h got=%b exp=%b", n, ir, bus.branch_c, exp_br); end
            if (exp_br) begin
                checks++; if (bus.branch_pc !== exp_pc) begin
                    errors++; $display("FAIL rnd_branch_pc n=%0d ir=%h got=%h exp=%h", n, ir, bus.branch_pc, exp_pc); end
            end
            if (!reset_n) begin
                m_idex = '0;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            end else begin
                nxt = m_decode(ir, npc);
                if (!(bus.ex_stall_c || bus.mem_stall_c)) m_idex = exp_stall ? ex_t'(0) : nxt;
                if (bus.wb_write_enable && bus.wb_write_reg != 0) m_regs[bus.wb_write_reg] = bus.wb_write_data;
            end
            tick();
            checks++; if (dut_idex() !== m_idex) begin
                errors++; $display("FAIL rnd_idex n=%0d got=%h exp=%h", n, dut_idex(), m_idex); end
        end
        reset_n = 1'b1;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_add_bypass();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
